// File: rtl/life_gen_sequencer_if.sv
// Control/status bundle between the Life board datapath controller and its sequencer.
interface life_gen_sequencer_if #(
  parameter int unsigned CellBits = 6,
  parameter int unsigned SpdW     = 4,
  parameter int unsigned GenW     = 16
);
  logic                frame_start;
  logic                run;
  logic                step;
  logic                load;
  logic [SpdW-1:0]     speed;
  logic [CellBits-1:0] cell_idx;
  logic                load_en;
  logic                copy_en;
  logic                compute_en;
  logic                disp_sel;
  logic                busy;
  logic                gen_done;
  logic [GenW-1:0]     gen_count;

  modport master (
    output frame_start, run, step, load, speed,
    input  cell_idx, load_en, copy_en, compute_en, disp_sel, busy, gen_done, gen_count
  );

  modport slave (
    input  frame_start, run, step, load, speed,
    output cell_idx, load_en, copy_en, compute_en, disp_sel, busy, gen_done, gen_count
  );
endinterface

// File: rtl/life_gen_sequencer.sv
// Sequences one Game-of-Life generation per N frames: LOAD seeds curr, COPY moves curr->prev,
// COMPUTE rebuilds curr from prev. Walks every cell index once per phase.
module life_gen_sequencer #(
  parameter int unsigned CellBits = 6,
  parameter int unsigned SpdW     = 4,
  parameter int unsigned GenW     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  life_gen_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCopy, StCompute} state_e;

  localparam logic [CellBits-1:0] CellMax = '1;

  state_e              state_q, state_d;
  logic [CellBits-1:0] cell_idx_q, cell_idx_d;
  logic                disp_sel_q, disp_sel_d;
  logic                gen_done_q, gen_done_d;
  logic [GenW-1:0]     gen_count_q, gen_count_d;
  logic [SpdW-1:0]     frame_cnt_q, frame_cnt_d;
  logic                step_pend_q, step_pend_d;
  logic                load_pend_q, load_pend_d;
  logic                start_load, start_copy;
  logic                last_cell;

  // State register; reset is synchronous and forces a fresh seed on the first frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cell_idx_q  <= '0;
      disp_sel_q  <= 1'b0;
      gen_done_q  <= 1'b0;
      gen_count_q <= '0;
      frame_cnt_q <= '0;
      step_pend_q <= 1'b0;
      load_pend_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cell_idx_q  <= cell_idx_d;
      disp_sel_q  <= disp_sel_d;
      gen_done_q  <= gen_done_d;
      gen_count_q <= gen_count_d;
      frame_cnt_q <= frame_cnt_d;
      step_pend_q <= step_pend_d;
      load_pend_q <= load_pend_d;
    end
  end

  // Next-state logic: phase sequencing, cell walk, pending requests and frame pacing.
  always_comb begin
    state_d     = state_q;
    cell_idx_d  = cell_idx_q;
    disp_sel_d  = disp_sel_q;
    gen_done_d  = 1'b0;
    gen_count_d = gen_count_q;
    start_load  = 1'b0;
    start_copy  = 1'b0;
    last_cell   = (cell_idx_q == CellMax);

    unique case (state_q)
      StIdle: begin
        cell_idx_d = '0;
        if (bus.frame_start) begin
          // Load outranks both free-run and single-step.
          if (load_pend_q) begin
            state_d    = StLoad;
            start_load = 1'b1;
          end else if (step_pend_q || (bus.run && (frame_cnt_q == bus.speed))) begin
            state_d    = StCopy;
            start_copy = 1'b1;
          end
        end
      end
      StLoad: begin
        cell_idx_d = cell_idx_q + 1'b1;
        if (last_cell) begin
          state_d     = StIdle;
          gen_count_d = '0;
        end
      end
      StCopy: begin
        cell_idx_d = cell_idx_q + 1'b1;
        if (last_cell) begin
          state_d    = StCompute;
          disp_sel_d = 1'b1;
        end
      end
      StCompute: begin
        cell_idx_d = cell_idx_q + 1'b1;
        if (last_cell) begin
          state_d     = StIdle;
          disp_sel_d  = 1'b0;
          gen_done_d  = 1'b1;
          gen_count_d = gen_count_q + 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        cell_idx_d = '0;
        disp_sel_d = 1'b0;
      end
    endcase

    // Frame pacing counter saturates at speed; a new generation restarts it.
    frame_cnt_d = frame_cnt_q;
    if (start_copy) begin
      frame_cnt_d = '0;
    end else if (bus.frame_start && bus.run) begin
      frame_cnt_d = (frame_cnt_q >= bus.speed) ? bus.speed : frame_cnt_q + 1'b1;
    end

    // A step while free-running is meaningless and is dropped.
    load_pend_d = bus.load | (load_pend_q & ~start_load);
    step_pend_d = (bus.step & ~bus.run) | (step_pend_q & ~start_copy);
  end

  // Outputs decode straight from the registered state.
  always_comb begin
    bus.cell_idx   = cell_idx_q;
    bus.load_en    = (state_q == StLoad);
    bus.copy_en    = (state_q == StCopy);
    bus.compute_en = (state_q == StCompute);
    bus.disp_sel   = disp_sel_q;
    bus.busy       = (state_q != StIdle);
    bus.gen_done   = gen_done_q;
    bus.gen_count  = gen_count_q;
  end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: directed scenarios plus randomized frames against a
// frame-level model of the pending flags, frame pacing and generation count.
module tb_life_gen_sequencer;
  localparam int N  = 64;
  localparam int CB = 6;
  localparam int SW = 4;
  // Narrow generation counter so the wrap is reachable in a short run.
  localparam int GW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  life_gen_sequencer_if #(.CellBits(CB), .SpdW(SW), .GenW(GW)) bus ();

  life_gen_sequencer #(.CellBits(CB), .SpdW(SW), .GenW(GW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference state.
  bit m_load_pend;
  bit m_step_pend;
  int m_cnt;
  int m_gen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase codes: 0 idle, 1 load, 2 copy, 3 compute.
  function automatic logic [31:0] exp_vec(input int ph, input int idx, input bit done);
    logic [5:0] ci;
    ci = 6'(idx);
    return {18'b0, ph == 1, ph == 2, ph == 3, ph == 3, ph != 0, done, 2'b00, ci};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {18'b0, bus.load_en, bus.copy_en, bus.compute_en, bus.disp_sel, bus.busy,
            bus.gen_done, 2'b00, bus.cell_idx};
  endfunction

  task automatic check_cycle(input string tag, input int ph, input int idx, input bit done);
    check_eq(tag, obs_vec(), exp_vec(ph, idx, done));
    check_eq({tag, "_onehot"}, 32'($onehot0({bus.load_en, bus.copy_en, bus.compute_en})), 32'd1);
  endtask

  task automatic check_gen(input string tag);
    check_eq(tag, 32'(bus.gen_count), 32'(m_gen % (1 << GW)));
  endtask

  function automatic int sat(input int c);
    return (c >= int'(bus.speed)) ? int'(bus.speed) : c + 1;
  endfunction

  task automatic model_reset();
    m_load_pend = 1'b1;
    m_step_pend = 1'b0;
    m_cnt       = 0;
    m_gen       = 0;
  endtask

  // Idle cycles with optional step/load pulses on the first one.
  task automatic idle_gap(input int k, input bit do_step, input bit do_load);
    bus.step = do_step;
    bus.load = do_load;
    if (do_step && !bus.run) m_step_pend = 1'b1;
    if (do_load) m_load_pend = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.load = 1'b0;
    for (int i = 0; i < k; i++) tick();
  endtask

  // One frame_start from idle; the *_at arguments inject events at phase cycle j (-1 = none).
  task automatic do_frame(input int load_at, input int fs_at, input int runlow_at,
                          input int rst_at);
    int mode;
    int len;
    int ph;
    if (m_load_pend) begin
      mode = 1;
      m_load_pend = 1'b0;
      if (bus.run) m_cnt = sat(m_cnt);
    end else if (m_step_pend || (bus.run && m_cnt == int'(bus.speed))) begin
      mode = 2;
      m_step_pend = 1'b0;
      m_cnt = 0;
    end else begin
      mode = 0;
      if (bus.run) m_cnt = sat(m_cnt);
    end
    len = (mode == 0) ? 0 : (mode == 1) ? N : 2 * N;

    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;

    for (int j = 1; j <= len; j++) begin
      ph = (mode == 1) ? 1 : ((j <= N) ? 2 : 3);
      check_cycle("phase", ph, (j - 1) % N, 1'b0);
      if (j == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check_cycle("reset_mid", 0, 0, 1'b0);
        check_gen("reset_gen_count");
        return;
      end
      if (j == runlow_at) bus.run = 1'b0;
      if (j == load_at) begin
        bus.load = 1'b1;
        m_load_pend = 1'b1;
      end
      if (j == fs_at) begin
        bus.frame_start = 1'b1;
        if (bus.run) m_cnt = sat(m_cnt);
      end
      tick();
      bus.load = 1'b0;
      bus.frame_start = 1'b0;
    end

    if (mode == 1) m_gen = 0;
    if (mode == 2) m_gen++;
    check_cycle("frame_end", 0, 0, mode == 2);
    check_gen("gen_count");
    tick();
    check_cycle("post_end", 0, 0, 1'b0);
  endtask

  initial begin
    int g0;
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.run = 1'b0;
    bus.step = 1'b0;
    bus.load = 1'b0;
    bus.speed = '0;
    model_reset();
    tick();
    tick();
    check_cycle("reset", 0, 0, 1'b0);
    check_gen("reset_gen_count");
    rst_n = 1'b1;
    idle_gap(2, 1'b0, 1'b0);

    // First frame after reset seeds the board.
    do_frame(-1, -1, -1, -1);

    // Free-running every frame.
    bus.run = 1'b1;
    bus.speed = 4'd0;
    for (int i = 0; i < 3; i++) begin
      idle_gap(3, 1'b0, 1'b0);
      do_frame(-1, -1, -1, -1);
    end

    // Every 4th frame.
    bus.speed = 4'd3;
    g0 = m_gen;
    for (int i = 0; i < 8; i++) begin
      idle_gap(2, 1'b0, 1'b0);
      do_frame(-1, -1, -1, -1);
    end
    check_eq("speed3_gens", 32'((int'(bus.gen_count) - g0) & ((1 << GW) - 1)), 32'd2);

    // Single step while halted, then a dropped step while running.
    bus.run = 1'b0;
    idle_gap(2, 1'b1, 1'b0);
    do_frame(-1, -1, -1, -1);
    idle_gap(2, 1'b0, 1'b0);
    do_frame(-1, -1, -1, -1);
    bus.run = 1'b1;
    bus.speed = 4'd15;
    idle_gap(2, 1'b1, 1'b0);
    do_frame(-1, -1, -1, -1);

    // Load during COMPUTE is deferred; stray frame_start and run drop mid-generation.
    bus.speed = 4'd0;
    m_cnt = m_cnt;
    idle_gap(2, 1'b0, 1'b0);
    while (m_cnt != 0) begin
      do_frame(-1, -1, -1, -1);
      idle_gap(1, 1'b0, 1'b0);
    end
    do_frame(N + 10, 20, 90, -1);
    bus.run = 1'b1;
    idle_gap(2, 1'b0, 1'b0);
    do_frame(-1, -1, -1, -1);

    // Reset at cell 30 of COPY, then the next frame reloads.
    idle_gap(2, 1'b0, 1'b0);
    do_frame(-1, -1, -1, 31);
    idle_gap(2, 1'b0, 1'b0);
    do_frame(-1, -1, -1, -1);

    // Run long enough for the generation counter to wrap.
    for (int i = 0; i < (1 << GW) + 2; i++) begin
      idle_gap(1, 1'b0, 1'b0);
      do_frame(-1, -1, -1, -1);
    end

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      bus.run = 1'($urandom_range(0, 1));
      bus.speed = 4'($urandom_range(0, 2));
      idle_gap($urandom_range(1, 4), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      do_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * N) : -1,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * N) : -1,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * N) : -1,
               ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2 * N) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
